// File: rtl/ka_8bit_seq_ctrl.sv
// ka_8bit_seq_ctrl: multi-cycle Karatsuba 8x8 unsigned multiplier.
// One combinational 5x5 sub-multiplier is time-shared across the three partial
// products (z0 = aL*bL, z2 = aH*bH, z1 = (aL+aH)*(bL+bH)). Accepts an operand pair
// over valid/ready, then delivers the product over valid/ready.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid/in_ready, a, b      operand handshake (in_ready high only in IDLE)
//   out_valid/out_ready, y       result handshake (y = a*b, held until taken)
//   busy          high in every state except IDLE
//   ops_cnt       count of handed-off results, wraps modulo 2^OPS_W
//   err           sticky Karatsuba-vs-direct-multiply mismatch flag
//                 (only when KA_SEQ_SELFCHECK_EN is defined)
//
// Optional feature macro: KA_SEQ_SELFCHECK_EN.

module ka_8bit_seq_ctrl #(
  parameter int unsigned OPS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      y,
  output logic             busy,
  output logic [OPS_W-1:0] ops_cnt
`ifdef KA_SEQ_SELFCHECK_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StMulLo,
    StMulHi,
    StMulMid,
    StCombine,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       z0_q, z0_d;
  logic [7:0]       z2_q, z2_d;
  logic [9:0]       z1_q, z1_d;
  logic [15:0]      y_q, y_d;
  logic [OPS_W-1:0] ops_q, ops_d;

  // Shared sub-multiplier.
  logic [4:0]       mul_x, mul_y;
  logic [9:0]       mul_p;

  logic [4:0]       sum_a, sum_b;
  logic [9:0]       mid;
  logic [15:0]      y_comb;

  assign mul_p = {5'b0, mul_x} * {5'b0, mul_y};

  assign sum_a = {1'b0, a_q[3:0]} + {1'b0, a_q[7:4]};
  assign sum_b = {1'b0, b_q[3:0]} + {1'b0, b_q[7:4]};

  // z1 >= z0 + z2 always, so mid cannot underflow.
  assign mid    = z1_q - {2'b0, z2_q} - {2'b0, z0_q};
  assign y_comb = {z2_q, 8'h00} + {2'b0, mid, 4'h0} + {8'h00, z0_q};

`ifdef KA_SEQ_SELFCHECK_EN
  logic        err_q, err_d;
  logic [15:0] ref_p;

  assign ref_p = {8'h00, a_q} * {8'h00, b_q};
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z0_d    = z0_q;
    z2_d    = z2_q;
    z1_d    = z1_q;
    y_d     = y_q;
    ops_d   = ops_q;
    mul_x   = 5'd0;
    mul_y   = 5'd0;
`ifdef KA_SEQ_SELFCHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = StMulLo;
        end
      end
      StMulLo: begin
        mul_x   = {1'b0, a_q[3:0]};
        mul_y   = {1'b0, b_q[3:0]};
        z0_d    = mul_p[7:0];
        state_d = StMulHi;
      end
      StMulHi: begin
        mul_x   = {1'b0, a_q[7:4]};
        mul_y   = {1'b0, b_q[7:4]};
        z2_d    = mul_p[7:0];
        state_d = StMulMid;
      end
      StMulMid: begin
        mul_x   = sum_a;
        mul_y   = sum_b;
        z1_d    = mul_p;
        state_d = StCombine;
      end
      StCombine: begin
        y_d     = y_comb;
        state_d = StDone;
`ifdef KA_SEQ_SELFCHECK_EN
        if (ref_p != y_comb) begin
          err_d = 1'b1;
        end
`endif
      end
      StDone: begin
        if (out_ready) begin
          ops_d   = ops_q + OPS_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      z0_q    <= 8'h00;
      z2_q    <= 8'h00;
      z1_q    <= 10'h000;
      y_q     <= 16'h0000;
      ops_q   <= '0;
`ifdef KA_SEQ_SELFCHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      z1_q    <= z1_d;
      y_q     <= y_d;
      ops_q   <= ops_d;
`ifdef KA_SEQ_SELFCHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Handshake outputs decode state only.
  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;
  assign ops_cnt   = ops_q;
`ifdef KA_SEQ_SELFCHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_ka_8bit_seq_ctrl.sv
// Scoreboard bench for ka_8bit_seq_ctrl: stimulus pushes expected products,
// a negedge monitor pops and compares on each result handoff.

module tb_ka_8bit_seq_ctrl;

  localparam int OPS_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      y;
  logic             busy;
  logic [OPS_W-1:0] ops_cnt;
`ifdef KA_SEQ_SELFCHECK_EN
  logic             err;
`endif

  ka_8bit_seq_ctrl #(
    .OPS_W(OPS_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .busy     (busy),
    .ops_cnt  (ops_cnt)
`ifdef KA_SEQ_SELFCHECK_EN
    ,
    .err      (err)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_ops = 0;
  bit          chk_cnt = 0;
  logic [15:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each handed-off product and the counter after it.
  always @(negedge clk) begin
    if (chk_cnt) begin
      chk_cnt = 0;
      check("ops_cnt_after_handoff", 32'(ops_cnt), 32'(exp_ops[OPS_W-1:0]));
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got y=%0h expected no result", y);
      end else begin
        check("y", 32'(y), 32'(exp_q.pop_front()));
      end
      exp_ops = (exp_ops + 1) % (1 << OPS_W);
      chk_cnt = 1;
    end
  end

  // Issue one operand pair; returns at #1 after the edge where out_valid rises.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] ey,
                       input bit chg, output int acc_cyc);
    int n;
    int lat;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    exp_q.push_back(ey);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    if (chg) begin
      a = 8'hFF;
      b = 8'hFF;
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
  endtask

  int c0, c1;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_ops_cnt", 32'(ops_cnt), 32'd0);

    // Basic
    issue(8'hAB, 8'hDE, 16'h944A, 1'b0, c0);
    check("done_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("basic_ops_cnt", 32'(ops_cnt), 32'd1);
    check("basic_back_idle", 32'(in_ready), 32'd1);

    // Extremes
    issue(8'hFF, 8'hFF, 16'hFE01, 1'b0, c0);
    issue(8'h00, 8'h5A, 16'h0000, 1'b0, c0);
    issue(8'h0F, 8'hF0, 16'h0E10, 1'b0, c0);
    @(posedge clk);
    #1;

    // Backpressure with ignored in_valid while DONE
    out_ready = 1'b0;
    issue(8'h9C, 8'h37, 16'h2184, 1'b0, c0);
    a        = 8'h11;
    b        = 8'h22;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_y", 32'(y), 32'h2184);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after", 32'(in_ready), 32'd1);
    check("bp_busy_after", 32'(busy), 32'd0);
    check("bp_ops_cnt", 32'(ops_cnt), 32'd1);

    // Operands change after acceptance
    issue(8'h12, 8'h34, 16'h03A8, 1'b1, c0);
    @(posedge clk);
    #1;

    // Reset while in MUL_MID
    a        = 8'h77;
    b        = 8'h66;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midop_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_ops = 0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_ops_cnt", 32'(ops_cnt), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_result", 32'(out_valid), 32'd0);

    // Back-to-back: counter wraps 1,2,3,0 and acceptances 6 cycles apart
    issue(8'h01, 8'h01, 16'h0001, 1'b0, c0);
    issue(8'h80, 8'h02, 16'h0100, 1'b0, c1);
    check("ii_1", 32'(c1 - c0), 32'd6);
    c0 = c1;
    issue(8'hC3, 8'h5A, 16'h448E, 1'b0, c1);
    check("ii_2", 32'(c1 - c0), 32'd6);
    c0 = c1;
    issue(8'h10, 8'h10, 16'h0100, 1'b0, c1);
    check("ii_3", 32'(c1 - c0), 32'd6);
    @(posedge clk);
    #1;
    check("wrap_ops_cnt", 32'(ops_cnt), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef KA_SEQ_SELFCHECK_EN
    check("err_flag", 32'(err), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/ka_8bit_seq_ctrl.md
# ka_8bit_seq_ctrl

Multi-cycle Karatsuba sequencer for 8x8 unsigned multiplication that time-shares a single 5x5 sub-multiplier across the three Karatsuba partial products. It sits between a valid/ready operand source and a valid/ready result sink and replaces the fully combinational 8-bit Karatsuba multiplier where area matters more than latency. It also keeps a free-running count of completed products for throughput monitoring.

## Interface
- OPS_W, default 16: width of the completed-operation counter `ops_cnt`.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on `a`/`b` is valid.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  `y` holds a completed product.
- out_ready  input  1  sink accepts `y`.
- y  output  16  full unsigned product a*b.
- busy  output  1  high in every state except IDLE.
- ops_cnt  output  OPS_W  number of results handed off (out_valid && out_ready); wraps modulo 2^OPS_W.
- err  output  1  self-check mismatch flag; present only with KA_SEQ_SELFCHECK_EN.

## Operation
- States: IDLE -> MUL_LO -> MUL_HI -> MUL_MID -> COMBINE -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid && in_ready, register a, b; go to MUL_LO. Otherwise stay.
- MUL_LO: sub-multiplier inputs {1'b0,aL},{1'b0,bL}; register z0 (8 bits).
- MUL_HI: inputs {1'b0,aH},{1'b0,bH}; register z2 (8 bits).
- MUL_MID: inputs sa=aL+aH, sb=bL+bH (5 bits each, max 30); register z1 (10 bits, max 900).
- COMBINE: mid = z1 - z2 - z0 (10 bits, never negative); y = (z2<<8) + (mid<<4) + z0, computed in 16 bits with no truncation; register y; go to DONE.
- DONE: out_valid=1, y stable. On out_ready: ops_cnt increments, go to IDLE. Without out_ready: hold indefinitely, y and out_valid unchanged.
- Exactly one sub-multiplier instance; it is combinational, its output sampled at the end of each MUL_* state.
- Operands registered at acceptance; changes on a/b afterwards have no effect on the in-flight product.
- in_valid during any non-IDLE state is ignored (in_ready=0); no queuing.
- Reset (any state, including mid-operation): state=IDLE, operand/partial registers=0, y=16'h0000, out_valid=0, in_ready=1, busy=0, ops_cnt=0, err=0. In-flight operation is discarded, not reported.
- ops_cnt wraps from 2^OPS_W-1 to 0 with no flag.

## Timing
- Acceptance edge T (in_valid && in_ready sampled high). States MUL_LO, MUL_HI, MUL_MID, COMBINE occupy cycles T+1..T+4; out_valid is high from cycle T+5.
- Latency acceptance-to-out_valid: 5 cycles. Minimum initiation interval: 6 cycles (handoff in DONE, in_ready high the following cycle).
- in_ready and out_valid are never high in the same cycle.
- ops_cnt updates on the handoff edge; visible the following cycle.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- KA_SEQ_SELFCHECK_EN defined: `err` port exists; in COMBINE the block also computes a*b with a direct multiply and sets `err` (sticky until rst) if it differs from the Karatsuba result. Simulation/FPGA-debug use.
- Not defined: `err` port and reference multiplier absent; no other behavioural difference.

## Test plan
- Basic: reset 2 cycles, a=8'hAB, b=8'hDE, out_ready=1 -> out_valid at T+5 with y=16'h944A, ops_cnt=1, err=0.
- Extremes: a=8'hFF,b=8'hFF -> y=16'hFE01; a=8'h00,b=8'h5A -> y=16'h0000; a=8'h0F,b=8'hF0 -> y=16'h0E10.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> y, out_valid stable, in_ready=0, new in_valid ignored; then out_ready=1 -> one handoff, ops_cnt +1, IDLE next cycle.
- Operand change: after acceptance of 8'h12*8'h34, drive a=b=8'hFF -> y=16'h03A8.
- Reset mid-operation: rst pulsed in MUL_MID -> next cycle IDLE, out_valid=0, y=0, ops_cnt=0; no result emitted.
- Wrap/back-to-back: OPS_W=2, four consecutive products with out_ready=1 -> ops_cnt 1,2,3,0; in_ready rises exactly once per 6 cycles.
